// File: rtl/stream_demux1to2_if.sv
// rtl/stream_demux1to2_if.sv - handshake bundle for the 1-to-2 stream demultiplexer
interface stream_demux1to2_if #(
    parameter int N     = 32,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic             in_sel;
    logic [N-1:0]     in_data;
    logic             out0_valid;
    logic             out0_ready;
    logic [N-1:0]     out0_data;
    logic             out1_valid;
    logic             out1_ready;
    logic [N-1:0]     out1_data;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;

    modport slave (
        input  in_valid, in_sel, in_data, out0_ready, out1_ready,
        output in_ready, out0_valid, out0_data, out1_valid, out1_data, cnt0, cnt1
    );

    modport master (
        output in_valid, in_sel, in_data, out0_ready, out1_ready,
        input  in_ready, out0_valid, out0_data, out1_valid, out1_data, cnt0, cnt1
    );
endinterface

// File: rtl/stream_demux1to2.sv
// rtl/stream_demux1to2.sv - registered 1-to-2 stream demultiplexer over a 2-entry FIFO
module stream_demux1to2 #(
    parameter int N     = 32,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    stream_demux1to2_if.slave        bus
);
    logic [N:0]       mem [2];
    logic             head;
    logic             tail;
    logic [1:0]       count;
    logic             ready_en;
    logic [CNT_W-1:0] cnt0_q;
    logic [CNT_W-1:0] cnt1_q;

    logic             head_sel;
    logic [N-1:0]     head_data;
    logic             non_empty;
    logic             valid0;
    logic             valid1;
    logic             push;
    logic             pop0;
    logic             pop1;
    logic             pop;

    assign head_sel  = mem[head][N];
    assign head_data = mem[head][N-1:0];
    assign non_empty = (count != 2'd0);
    assign valid0    = non_empty && !head_sel;
    assign valid1    = non_empty && head_sel;

    // ready_en keeps in_ready low during reset and until the first edge after release
    assign bus.in_ready   = ready_en && (count != 2'd2);
    assign bus.out0_valid = valid0;
    assign bus.out1_valid = valid1;
    assign bus.out0_data  = valid0 ? head_data : '0;
    assign bus.out1_data  = valid1 ? head_data : '0;
    assign bus.cnt0       = cnt0_q;
    assign bus.cnt1       = cnt1_q;

    assign push = bus.in_valid && bus.in_ready;
    assign pop0 = valid0 && bus.out0_ready;
    assign pop1 = valid1 && bus.out1_ready;
    assign pop  = pop0 || pop1;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= {bus.in_sel, bus.in_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head     <= 1'b0;
            tail     <= 1'b0;
            count    <= 2'd0;
            ready_en <= 1'b0;
            cnt0_q   <= '0;
            cnt1_q   <= '0;
        end else begin
            ready_en <= 1'b1;
            if (push) begin
                tail <= ~tail;
            end
            if (pop) begin
                head <= ~head;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
            if (pop0) begin
                cnt0_q <= cnt0_q + 1'b1;
            end
            if (pop1) begin
                cnt1_q <= cnt1_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_stream_demux1to2.sv
// tb/tb_stream_demux1to2.sv - self-checking bench for stream_demux1to2
module tb_stream_demux1to2;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    stream_demux1to2_if #(.N(32), .CNT_W(16)) bus ();
    stream_demux1to2_if #(.N(8),  .CNT_W(2))  bus2 ();

    stream_demux1to2 #(.N(32), .CNT_W(16)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    stream_demux1to2 #(.N(8),  .CNT_W(2))  dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    typedef struct {
        bit          sel;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    int unsigned m_cnt0;
    int unsigned m_cnt1;
    bit          m_ready_en;
    int          checks = 0;
    int          errors = 0;

    function automatic bit exp_v0();
        return (q.size() > 0) && !q[0].sel;
    endfunction

    function automatic bit exp_v1();
        return (q.size() > 0) && q[0].sel;
    endfunction

    function automatic logic [31:0] exp_d0();
        return exp_v0() ? q[0].data : 32'h0;
    endfunction

    function automatic logic [31:0] exp_d1();
        return exp_v1() ? q[0].data : 32'h0;
    endfunction

    function automatic bit exp_ready();
        return m_ready_en && (q.size() < 2);
    endfunction

    // advance one clock; the model decides push/pop from the inputs held before the edge
    task automatic tick();
        bit   do_push;
        bit   do_pop;
        ent_t e;
        do_push = bus.in_valid && exp_ready();
        do_pop  = (q.size() > 0) && (q[0].sel ? bus.out1_ready : bus.out0_ready);
        e.sel   = bus.in_sel;
        e.data  = bus.in_data;
        @(posedge clk);
        #1;
        if (do_pop) begin
            if (q[0].sel) m_cnt1++;
            else          m_cnt0++;
            void'(q.pop_front());
        end
        if (do_push) q.push_back(e);
        m_ready_en = rst_n;
    endtask

    task automatic model_reset();
        q.delete();
        m_cnt0 = 0;
        m_cnt1 = 0;
        m_ready_en = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_valid = 0; bus.in_sel = 0; bus.in_data = '0;
        bus.out0_ready = 0; bus.out1_ready = 0;
        bus2.in_valid = 0; bus2.in_sel = 0; bus2.in_data = '0;
        bus2.out0_ready = 0; bus2.out1_ready = 0;
        rst_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0b want 0", bus.in_ready); end
        checks++;
        if ({bus.out0_valid, bus.out1_valid} !== 2'b00) begin errors++; $display("FAIL reset_valids got %b want 00", {bus.out0_valid, bus.out1_valid}); end
        checks++;
        if (bus.out0_data !== 32'h0 || bus.out1_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h %h want 0 0", bus.out0_data, bus.out1_data); end
        checks++;
        if (bus.cnt0 !== 16'h0 || bus.cnt1 !== 16'h0) begin errors++; $display("FAIL reset_cnt got %0d %0d want 0 0", bus.cnt0, bus.cnt1); end
        rst_n = 1;
        tick();
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %0b want 1", bus.in_ready); end
    endtask

    task automatic test_first_push();
        bus.out0_ready = 1; bus.out1_ready = 0;
        bus.in_valid = 1; bus.in_sel = 0; bus.in_data = 32'hDEADBEEF;
        tick();
        bus.in_valid = 0;
        checks++;
        if (bus.out0_valid !== 1'b1 || bus.out0_data !== 32'hDEADBEEF) begin errors++; $display("FAIL first_out0 got %0b %h want 1 deadbeef", bus.out0_valid, bus.out0_data); end
        checks++;
        if (bus.out1_valid !== 1'b0) begin errors++; $display("FAIL first_out1_valid got %0b want 0", bus.out1_valid); end
        tick();
        checks++;
        if (bus.cnt0 !== 16'd1) begin errors++; $display("FAIL first_cnt0 got %0d want 1", bus.cnt0); end
    endtask

    task automatic test_steering();
        bus.out0_ready = 1; bus.out1_ready = 1;
        bus.in_valid = 1; bus.in_sel = 1; bus.in_data = 32'h0000_0001;
        tick();
        checks++;
        if (bus.out1_valid !== 1'b1 || bus.out1_data !== 32'h1 || bus.out0_valid !== 1'b0) begin
            errors++; $display("FAIL steer_out1 got %0b %h v0=%0b want 1 00000001 v0=0", bus.out1_valid, bus.out1_data, bus.out0_valid);
        end
        bus.in_sel = 0; bus.in_data = 32'hFFFF_FFFF;
        tick();
        bus.in_valid = 0;
        checks++;
        if (bus.out0_valid !== 1'b1 || bus.out0_data !== 32'hFFFF_FFFF || bus.out1_valid !== 1'b0) begin
            errors++; $display("FAIL steer_out0 got %0b %h v1=%0b want 1 ffffffff v1=0", bus.out0_valid, bus.out0_data, bus.out1_valid);
        end
        tick();
        checks++;
        if (bus.cnt0 !== 16'd2 || bus.cnt1 !== 16'd1) begin errors++; $display("FAIL steer_cnt got %0d %0d want 2 1", bus.cnt0, bus.cnt1); end
    endtask

    task automatic test_backpressure();
        logic [31:0] words [3];
        bit          want_ready [3];
        for (int i = 0; i < 3; i++) words[i] = $urandom;
        want_ready[0] = 1; want_ready[1] = 1; want_ready[2] = 0;
        bus.out0_ready = 0; bus.out1_ready = 1;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1; bus.in_sel = 0; bus.in_data = words[i];
            checks++;
            if (bus.in_ready !== want_ready[i]) begin errors++; $display("FAIL bp_in_ready[%0d] got %0b want %0b", i, bus.in_ready, want_ready[i]); end
            tick();
        end
        bus.in_valid = 0;
        repeat (2) begin
            checks++;
            if (bus.out0_valid !== 1'b1 || bus.out0_data !== words[0]) begin errors++; $display("FAIL bp_hold got %0b %h want 1 %h", bus.out0_valid, bus.out0_data, words[0]); end
            tick();
        end
        bus.out0_ready = 1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (bus.out0_data !== words[i]) begin errors++; $display("FAIL bp_drain[%0d] got %h want %h", i, bus.out0_data, words[i]); end
            tick();
        end
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out0_valid !== 1'b0) begin errors++; $display("FAIL bp_after got ready=%0b v0=%0b want 1 0", bus.in_ready, bus.out0_valid); end
    endtask

    task automatic test_hol_blocking();
        logic [31:0] x;
        logic [31:0] y;
        x = $urandom; y = $urandom;
        bus.out0_ready = 0; bus.out1_ready = 1;
        bus.in_valid = 1; bus.in_sel = 0; bus.in_data = x;
        tick();
        bus.in_sel = 1; bus.in_data = y;
        tick();
        bus.in_valid = 0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.out1_valid !== 1'b0 || bus.out0_data !== x) begin errors++; $display("FAIL hol_block[%0d] got v1=%0b d0=%h want 0 %h", i, bus.out1_valid, bus.out0_data, x); end
            tick();
        end
        bus.out0_ready = 1;
        tick();
        checks++;
        if (bus.out1_valid !== 1'b1 || bus.out1_data !== y || bus.out0_valid !== 1'b0) begin
            errors++; $display("FAIL hol_release got v1=%0b d1=%h v0=%0b want 1 %h 0", bus.out1_valid, bus.out1_data, bus.out0_valid, y);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int unsigned c0;
        int unsigned c1;
        c0 = m_cnt0; c1 = m_cnt1;
        bus.out0_ready = 1; bus.out1_ready = 1;
        for (int i = 0; i < 100; i++) begin
            bus.in_valid = 1; bus.in_sel = i[0]; bus.in_data = $urandom;
            if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d] got %0b want 1", i, bus.in_ready); end
            if (i > 0 && (bus.out0_valid !== exp_v0() || bus.out1_valid !== exp_v1()
                          || bus.out0_data !== exp_d0() || bus.out1_data !== exp_d1()
                          || (bus.out0_valid | bus.out1_valid) !== 1'b1)) begin
                errors++; $display("FAIL stream_out[%0d] got %0b%0b %h %h want %0b%0b %h %h", i, bus.out0_valid, bus.out1_valid,
                                   bus.out0_data, bus.out1_data, exp_v0(), exp_v1(), exp_d0(), exp_d1());
            end
            checks++;
            tick();
        end
        bus.in_valid = 0;
        repeat (2) tick();
        checks++;
        if (m_cnt0 - c0 != 50 || m_cnt1 - c1 != 50 || bus.cnt0 !== 16'(m_cnt0) || bus.cnt1 !== 16'(m_cnt1)) begin
            errors++; $display("FAIL stream_cnt got %0d %0d want %0d %0d", bus.cnt0, bus.cnt1, 16'(c0 + 50), 16'(c1 + 50));
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bus.in_valid = $urandom_range(0, 1); bus.in_sel = $urandom_range(0, 1); bus.in_data = $urandom;
            bus.out0_ready = ($urandom_range(0, 3) != 0); bus.out1_ready = ($urandom_range(0, 3) != 0);
            checks++;
            if (bus.in_ready !== exp_ready() || bus.out0_valid !== exp_v0() || bus.out1_valid !== exp_v1()
                || bus.out0_data !== exp_d0() || bus.out1_data !== exp_d1()
                || bus.cnt0 !== 16'(m_cnt0) || bus.cnt1 !== 16'(m_cnt1)) begin
                errors++; $display("FAIL random[%0d] got r=%0b v=%0b%0b d=%h/%h c=%0d/%0d want r=%0b v=%0b%0b d=%h/%h c=%0d/%0d", i,
                                   bus.in_ready, bus.out0_valid, bus.out1_valid, bus.out0_data, bus.out1_data, bus.cnt0, bus.cnt1,
                                   exp_ready(), exp_v0(), exp_v1(), exp_d0(), exp_d1(), 16'(m_cnt0), 16'(m_cnt1));
            end
            tick();
        end
        bus.in_valid = 0;
    endtask

    task automatic test_reset_mid();
        bus.out0_ready = 0; bus.out1_ready = 0;
        bus.in_valid = 1; bus.in_sel = $urandom_range(0, 1); bus.in_data = $urandom;
        repeat (3) tick();
        bus.in_valid = 0;
        checks++;
        if (bus.in_ready !== 1'b0 || (bus.out0_valid | bus.out1_valid) !== 1'b1) begin
            errors++; $display("FAIL mid_full got r=%0b v=%0b%0b want r=0 one valid", bus.in_ready, bus.out0_valid, bus.out1_valid);
        end
        @(negedge clk);
        rst_n = 0;
        #1;
        model_reset();
        checks++;
        if ({bus.out0_valid, bus.out1_valid} !== 2'b00 || bus.cnt0 !== 16'h0 || bus.cnt1 !== 16'h0 || bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL mid_reset got v=%0b%0b c=%0d/%0d r=%0b want 00 0/0 0", bus.out0_valid, bus.out1_valid, bus.cnt0, bus.cnt1, bus.in_ready);
        end
        @(posedge clk); #1;
        rst_n = 1;
        tick();
        bus.out0_ready = 1; bus.out1_ready = 1;
        repeat (2) tick();
        checks++;
        if ({bus.out0_valid, bus.out1_valid} !== 2'b00 || bus.cnt0 !== 16'h0 || bus.cnt1 !== 16'h0) begin
            errors++; $display("FAIL mid_discard got v=%0b%0b c=%0d/%0d want 00 0/0", bus.out0_valid, bus.out1_valid, bus.cnt0, bus.cnt1);
        end
    endtask

    task automatic test_counter_wrap();
        bus2.out0_ready = 1; bus2.out1_ready = 1;
        for (int i = 0; i < 5; i++) begin
            bus2.in_valid = 1; bus2.in_sel = 0; bus2.in_data = 8'(i + 1);
            @(posedge clk); #1;
        end
        bus2.in_valid = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus2.cnt0 !== 2'd1 || bus2.cnt1 !== 2'd0) begin errors++; $display("FAIL wrap_cnt got %0d %0d want 1 0", bus2.cnt0, bus2.cnt1); end
    endtask

    initial begin
        test_reset();
        test_first_push();
        test_steering();
        test_backpressure();
        test_hol_blocking();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_counter_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout");
        $fatal(1);
    end
endmodule
